// File: rtl/mem_check_pkg.sv
// Shared types and default sweep geometry for the Memoria32 read-back checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, 32-bit word type, default BASE/LIMIT/STRIDE/RD_LAT/ERR_W,
//           and the expected-pattern helper used by the comparator.
package mem_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [31:0] word_t;

    localparam word_t DEF_BASE   = 32'd0;
    localparam word_t DEF_LIMIT  = 32'd64;
    localparam word_t DEF_STRIDE = 32'd4;
    localparam int    DEF_RD_LAT = 1;
    localparam int    DEF_ERR_W  = 16;

    // Pattern the writer laid down: each word holds its own byte address plus an offset.
    function automatic word_t exp_word(input word_t addr, input word_t offset);
        return addr + offset;
    endfunction

endpackage

// File: rtl/mem_addr_pipe.sv
// Delay line of {valid, address} that lines issued read addresses up with returning data.
// Latency: DEPTH cycles from i_vld/i_addr to o_vld/o_addr.
// Backpressure: none; shifts every cycle.
// Ports: clk, nrst (async active-low); i_vld/i_addr push side; o_vld/o_addr aligned output;
//        o_pend = a valid entry is still behind the output stage.
module mem_addr_pipe
    import mem_check_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  nrst,
    input  logic  i_vld,
    input  word_t i_addr,
    output logic  o_vld,
    output word_t o_addr,
    output logic  o_pend
);

    logic [DEPTH-1:0] r_vld;
    word_t            r_addr [DEPTH];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_vld[0]  <= i_vld;
            r_addr[0] <= i_addr;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_addr[i] <= r_addr[i-1];
            end
        end
    end

    assign o_vld  = r_vld[DEPTH-1];
    assign o_addr = r_addr[DEPTH-1];

    // Only the stages ahead of the output matter: the output entry is consumed this cycle.
    always_comb begin
        o_pend = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            o_pend = o_pend | r_vld[i];
        end
    end

endmodule

// File: rtl/mem_readback_checker32.sv
// Sweeps [BASE, LIMIT) on the Memoria32 read port, one word per cycle, and checks data = addr + EXP_OFFSET.
// Latency: start to done = N + RD_LAT + 1 cycles, counting the start cycle (N = words swept).
// Backpressure: none; a read is issued every RUN cycle, start is ignored while busy.
// Ports: clk, nrst (async active-low), start pulse; rdaddress -> Memoria32 raddress, q <- Dataout;
//        busy (RUN/DRAIN), done (held), pass, err_count (saturating), first_err_addr.
module mem_readback_checker32
    import mem_check_pkg::*;
#(
    parameter word_t BASE       = DEF_BASE,
    parameter word_t LIMIT      = DEF_LIMIT,
    parameter word_t STRIDE     = DEF_STRIDE,
    parameter word_t EXP_OFFSET = 32'd0,
    parameter int    RD_LAT     = DEF_RD_LAT,
    parameter int    ERR_W      = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    output logic [31:0]      rdaddress,
    input  logic [31:0]      q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      first_err_addr
);

    state_t           r_state;
    state_t           w_state_nxt;
    word_t            r_addr;
    logic [ERR_W-1:0] r_err;
    word_t            r_first;

    word_t            w_next_addr;
    logic             w_last;
    logic             w_start_ok;
    logic             w_cmp_vld;
    word_t            w_cmp_addr;
    logic             w_pend;
    logic             w_mismatch;

    // Compare on the incremented address so the sweep never wraps past 2^32.
    assign w_next_addr = r_addr + STRIDE;
    assign w_last      = !(w_next_addr < LIMIT);
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));

    mem_addr_pipe #(
        .DEPTH (RD_LAT)
    ) u_addr_pipe (
        .clk    (clk),
        .nrst   (nrst),
        .i_vld  (r_state == RUN),
        .i_addr (r_addr),
        .o_vld  (w_cmp_vld),
        .o_addr (w_cmp_addr),
        .o_pend (w_pend)
    );

    assign w_mismatch = w_cmp_vld && (q != exp_word(w_cmp_addr, EXP_OFFSET));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = RUN;
            RUN:     if (w_last)     w_state_nxt = DRAIN;
            // Leave on the edge that performs the final compare.
            DRAIN:   if (!w_pend)    w_state_nxt = DONE;
            DONE:    if (w_start_ok) w_state_nxt = RUN;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_err   <= '0;
            r_first <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_start_ok) begin
                r_addr <= BASE;
            end else if ((r_state == RUN) && !w_last) begin
                r_addr <= w_next_addr;
            end

            // The pipe is empty in IDLE/DONE, so a start never coincides with a mismatch.
            if (w_start_ok) begin
                r_err   <= '0;
                r_first <= '0;
            end else if (w_mismatch) begin
                if (r_err != {ERR_W{1'b1}}) begin
                    r_err <= r_err + ERR_W'(1);
                end
                // A zero count marks the first failure; saturation never returns it to zero.
                if (r_err == '0) begin
                    r_first <= w_cmp_addr;
                end
            end
        end
    end

    assign rdaddress      = r_addr;
    assign busy           = (r_state == RUN) || (r_state == DRAIN);
    assign done           = (r_state == DONE);
    assign pass           = (r_state == DONE) && (r_err == '0);
    assign err_count      = r_err;
    assign first_err_addr = r_first;

endmodule

// File: tb/tb_mem_readback_checker32.sv
module tb_mem_readback_checker32;

    logic        clk;
    logic        nrst;
    logic        start_v [3];
    logic [31:0] rd_v    [3];
    logic [31:0] q_v     [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        pass_v  [3];
    logic [31:0] first_v [3];
    logic [15:0] err_a;
    logic [15:0] err_b;
    logic [1:0]  err_c;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] mem_c [16];
    logic [31:0] b0, b1, b2;

    int n_vec;
    int n_err;
    int nb;
    int nc;

    // Default geometry, RD_LAT=1
    mem_readback_checker32 u_dut_a (
        .clk(clk), .nrst(nrst), .start(start_v[0]), .rdaddress(rd_v[0]), .q(q_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_a),
        .first_err_addr(first_v[0])
    );

    mem_readback_checker32 #(.RD_LAT(3)) u_dut_b (
        .clk(clk), .nrst(nrst), .start(start_v[1]), .rdaddress(rd_v[1]), .q(q_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_b),
        .first_err_addr(first_v[1])
    );

    mem_readback_checker32 #(.ERR_W(2)) u_dut_c (
        .clk(clk), .nrst(nrst), .start(start_v[2]), .rdaddress(rd_v[2]), .q(q_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_c),
        .first_err_addr(first_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memoria32 read models: one-cycle port for a/c, three-stage port for b.
    always @(posedge clk) begin
        q_v[0] <= mem_a[rd_v[0][5:2]];
        q_v[2] <= mem_c[rd_v[2][5:2]];
        b0     <= mem_b[rd_v[1][5:2]];
        b1     <= b0;
        b2     <= b1;
    end
    assign q_v[1] = b2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pulse start on unit u, then count cycles until done. poke>0 re-pulses start
    // mid-sweep at that cycle; seq checks the issued address sequence 0,4,...,60.
    task automatic run(input int u, input int poke, input bit seq,
                       output int nbusy, output int ncyc);
        nbusy = 0;
        @(negedge clk);
        start_v[u] = 1'b1;
        @(negedge clk);
        start_v[u] = 1'b0;
        ncyc = 1;
        chk("done_drop", {31'b0, done_v[u]}, 32'd0);
        while (ncyc < 200) begin
            if (done_v[u]) break;
            start_v[u] = (ncyc == poke);
            if (busy_v[u]) begin
                if (seq && nbusy < 16) chk("rdaddr_seq", rd_v[u], 32'(nbusy * 4));
                nbusy++;
            end
            @(negedge clk);
            ncyc++;
        end
        start_v[u] = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        nrst  = 1'b0;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 32'(i * 4);
            mem_b[i] = 32'(i * 4);
            mem_c[i] = ~32'(i * 4);
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdaddr", rd_v[0], 32'd0);
        chk("rst_busy",   {31'b0, busy_v[0]}, 32'd0);
        chk("rst_done",   {31'b0, done_v[0]}, 32'd0);
        chk("rst_pass",   {31'b0, pass_v[0]}, 32'd0);
        chk("rst_err",    {16'b0, err_a}, 32'd0);
        chk("rst_first",  first_v[0], 32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_done",  {31'b0, done_v[0]}, 32'd0);

        // 1: clean sweep, RD_LAT=1
        run(0, 0, 1'b1, nb, nc);
        chk("t1_busy_cyc", nb, 32'd17);
        chk("t1_done_cyc", nc, 32'd18);
        chk("t1_done",  {31'b0, done_v[0]}, 32'd1);
        chk("t1_pass",  {31'b0, pass_v[0]}, 32'd1);
        chk("t1_err",   {16'b0, err_a}, 32'd0);
        chk("t1_first", first_v[0], 32'd0);
        chk("t1_rdhold", rd_v[0], 32'd60);

        // 2: two corrupted words
        mem_a[8]  = 32'hDEADBEEF;
        mem_a[12] = 32'h0;
        run(0, 0, 1'b0, nb, nc);
        chk("t2_done_cyc", nc, 32'd18);
        chk("t2_done",  {31'b0, done_v[0]}, 32'd1);
        chk("t2_pass",  {31'b0, pass_v[0]}, 32'd0);
        chk("t2_err",   {16'b0, err_a}, 32'd2);
        chk("t2_first", first_v[0], 32'h20);
        mem_a[8]  = 32'h20;
        mem_a[12] = 32'h30;

        // 6: start while busy is ignored, start in DONE reruns identically
        run(0, 5, 1'b1, nb, nc);
        chk("t6_busy_cyc", nb, 32'd17);
        chk("t6_done_cyc", nc, 32'd18);
        chk("t6_pass",  {31'b0, pass_v[0]}, 32'd1);
        chk("t6_err",   {16'b0, err_a}, 32'd0);
        run(0, 0, 1'b0, nb, nc);
        chk("t6_rerun_cyc", nc, 32'd18);
        chk("t6_rerun_pass", {31'b0, pass_v[0]}, 32'd1);
        chk("t6_rerun_err",  {16'b0, err_a}, 32'd0);

        // 3: RD_LAT=3, clean
        run(1, 0, 1'b0, nb, nc);
        chk("t3_busy_cyc", nb, 32'd19);
        chk("t3_done_cyc", nc, 32'd20);
        chk("t3_done",  {31'b0, done_v[1]}, 32'd1);
        chk("t3_pass",  {31'b0, pass_v[1]}, 32'd1);
        chk("t3_err",   {16'b0, err_b}, 32'd0);

        // 4: every word wrong, 2-bit counter saturates
        run(2, 0, 1'b0, nb, nc);
        chk("t4_done_cyc", nc, 32'd18);
        chk("t4_done",  {31'b0, done_v[2]}, 32'd1);
        chk("t4_pass",  {31'b0, pass_v[2]}, 32'd0);
        chk("t4_err",   {30'b0, err_c}, 32'd3);
        chk("t4_first", first_v[2], 32'd0);

        // 5: reset mid-sweep at rdaddress 0x18, with one error already counted
        mem_a[2] = 32'h12345678;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rd_v[0] == 32'h18) break;
            @(negedge clk);
        end
        chk("t5_reach", rd_v[0], 32'h18);
        chk("t5_err_pre", {16'b0, err_a}, 32'd1);
        nrst = 1'b0;
        #1;
        chk("t5_rdaddr", rd_v[0], 32'd0);
        chk("t5_busy",   {31'b0, busy_v[0]}, 32'd0);
        chk("t5_done",   {31'b0, done_v[0]}, 32'd0);
        chk("t5_err",    {16'b0, err_a}, 32'd0);
        chk("t5_first",  first_v[0], 32'd0);
        mem_a[2] = 32'h8;
        @(negedge clk);
        nrst = 1'b1;
        run(0, 0, 1'b1, nb, nc);
        chk("t5_rerun_cyc",  nc, 32'd18);
        chk("t5_rerun_pass", {31'b0, pass_v[0]}, 32'd1);
        chk("t5_rerun_err",  {16'b0, err_a}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_readback_checker32.md
Name: mem_readback_checker32

Overview:
Hardware read-back checker for the Memoria32 read port. Once a writer has filled a region with a known pattern, this block sweeps that region. It issues one word read per cycle on raddress and compares each returned Dataout word against the expected pattern. It reports pass/fail, a saturating error count and the first failing address, so memory fill can be self-checked in hardware instead of by waveform inspection.

Parameters:
BASE, 0, first byte address checked (multiple of STRIDE)
LIMIT, 64, exclusive end byte address; LIMIT > BASE, (LIMIT-BASE) multiple of STRIDE
STRIDE, 4, byte increment per word
EXP_OFFSET, 0, expected word = address + EXP_OFFSET (mod 2^32)
RD_LAT, 1, Memoria32 read latency in clk cycles (1..4)
ERR_W, 16, width of error counter

Ports:
clk  in  1  system clock, all state on rising edge
nrst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a sweep when in IDLE or DONE
rdaddress  out  32  read address to Memoria32 raddress
q  in  32  read data from Memoria32 Dataout
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE, held until next start or reset
pass  out  1  valid when done; 1 iff err_count == 0
err_count  out  ERR_W  number of mismatching words, saturates at all-ones
first_err_addr  out  32  address of first mismatch; 0 if none

Behaviour:
- Reset (nrst=0, async): state=IDLE; rdaddress=0; busy=0; done=0; pass=0; err_count=0; first_err_addr=0; address pipeline valids cleared. Reset mid-sweep aborts immediately with no partial result retained.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: outputs hold reset values. On start: rdaddress<=BASE, clear err_count/first_err_addr/pass, go to RUN.
- RUN: each cycle, push (rdaddress, valid=1) into an RD_LAT-deep pipeline. If rdaddress+STRIDE < LIMIT, rdaddress<=rdaddress+STRIDE. Otherwise rdaddress holds the last address and the state goes to DRAIN.
- DRAIN: push valid=0 bubbles. When the pipeline holds no valid entries after the last compare, go to DONE.
- Compare: when the pipeline output is valid, q is sampled that same cycle. Mismatch if q != addr_out + EXP_OFFSET (32-bit wrap).
- On mismatch: err_count increments unless already all-ones (saturate). On the first mismatch only, first_err_addr <= addr_out.
- Sweep latency: the first compare happens RD_LAT cycles after the first address is issued. Total start-to-done = N + RD_LAT + 1 cycles, where N = (LIMIT-BASE)/STRIDE. done rises on the cycle state enters DONE.
- DONE: done=1, pass=(err_count==0), busy=0. Results are held. A start pulse re-enters RUN exactly as from IDLE and drops done the next cycle.
- start while busy: ignored, with no restart and no effect on counters.
- start coincident with reset release edge: ignored; reset dominates.
- rdaddress advances every RUN cycle with no stalls; Memoria32 accepts one read per cycle.
- Address arithmetic is 32-bit unsigned. The LIMIT comparison uses the incremented value, so no wrap past 2^32 can occur for legal parameters.
- err_count counts words, not bits.

Decomposition:
- Package mem_check_pkg: state enum (IDLE, RUN, DRAIN, DONE); typedef word_t = logic [31:0]; default constants for BASE, LIMIT, STRIDE and RD_LAT shared with the writer-side bench.
- One sub-module, mem_addr_pipe: parameterised RD_LAT-deep shift register of {valid, address}, async active-low reset. It realigns issued addresses with returning q.
- Top holds the FSM, address counter, comparator and result registers.

Test Plan:
1. Memory filled with word[a]=a for a=0..60 step 4, EXP_OFFSET=0, start -> rdaddress 0,4,...,60; busy for 17 cycles; done=1, pass=1, err_count=0, first_err_addr=0.
2. Same fill, but word at 0x20 corrupted to 0xDEADBEEF and at 0x30 to 0 -> done=1, pass=0, err_count=2, first_err_addr=0x20.
3. RD_LAT=3 with a 3-stage read model, clean fill -> first compare 3 cycles after issue of 0; done after N+4=20 cycles; pass=1.
4. Every word wrong with ERR_W=2 -> err_count saturates at 3, first_err_addr=BASE, pass=0.
5. nrst pulsed low during RUN at rdaddress=0x18 -> all outputs return to reset values immediately. A new start runs a full clean sweep with pass=1.
6. start pulsed while busy and again in DONE -> the busy pulse is ignored and the sweep ends unchanged. The DONE pulse clears done next cycle and reruns with identical results.
